// File: rtl/prim_clock_sel_ctrl.sv
// Glitch-free select sequencer for a two-input clock mux: gates the muxed clock,
// flips the registered select only while gated, lets it settle, then re-enables.
module prim_clock_sel_ctrl #(
    parameter int   GateCycles   = 4,
    parameter int   SettleCycles = 4,
    parameter logic ResetSel     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    input  logic sel_req_i,
    output logic ack_o,
    output logic busy_o,
    output logic sel_o,
    output logic clk_en_o
);

    localparam int MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
    localparam int CntWidth  = $clog2(MaxCycles + 1);
    localparam logic [CntWidth-1:0] GateLoad   = CntWidth'(GateCycles - 1);
    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SettleCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        GATE_OFF,
        SETTLE,
        ACK
    } state_t;

    state_t              state;
    logic [CntWidth-1:0] count;
    logic                target;

    // Every output is computed for the next state so it leaves a flop with no
    // combinational path from the request inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            count    <= '0;
            target   <= ResetSel;
            sel_o    <= ResetSel;
            clk_en_o <= 1'b1;
            ack_o    <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    clk_en_o <= 1'b1;
                    busy_o   <= 1'b0;
                    if (req_i) begin
                        target <= sel_req_i;
                        busy_o <= 1'b1;
                        if (sel_req_i == sel_o) begin
                            state <= ACK;
                            ack_o <= 1'b1;
                        end else begin
                            state    <= GATE_OFF;
                            clk_en_o <= 1'b0;
                            count    <= GateLoad;
                        end
                    end
                end
                // The select only moves here, with the gate already closed
                // for the full gating window.
                GATE_OFF: begin
                    if (count == '0) begin
                        sel_o <= target;
                        count <= SettleLoad;
                        state <= SETTLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                SETTLE: begin
                    if (count == '0) begin
                        state    <= ACK;
                        clk_en_o <= 1'b1;
                        ack_o    <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                ACK: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clk_en_o <= 1'b1;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prim_clock_sel_ctrl.sv
// Directed bench for prim_clock_sel_ctrl: a vector table on a default-parameter
// instance plus a hand-written back-to-back sequence on a 1/1-cycle instance.
module tb_prim_clock_sel_ctrl;

    logic clk;
    logic rst, req, sel_req;
    logic ack, busy, sel, clk_en;
    logic rst2, req2, sel_req2;
    logic ack2, busy2, sel2, clk_en2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic req;
        logic sel_req;
        logic rst;
        logic ack;
        logic busy;
        logic sel;
        logic clk_en;
    } vec_t;

    vec_t vecs[$];

    prim_clock_sel_ctrl dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .sel_req_i (sel_req),
        .ack_o     (ack),
        .busy_o    (busy),
        .sel_o     (sel),
        .clk_en_o  (clk_en)
    );

    prim_clock_sel_ctrl #(
        .GateCycles   (1),
        .SettleCycles (1),
        .ResetSel     (1'b0)
    ) dut_fast (
        .clk_i     (clk),
        .rst_i     (rst2),
        .req_i     (req2),
        .sel_req_i (sel_req2),
        .ack_o     (ack2),
        .busy_o    (busy2),
        .sel_o     (sel2),
        .clk_en_o  (clk_en2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic r, input logic s, input logic rs,
                                    input logic a, input logic b, input logic sl,
                                    input logic en);
        vec_t v;
        v.req = r; v.sel_req = s; v.rst = rs;
        v.ack = a; v.busy = b; v.sel = sl; v.clk_en = en;
        vecs.push_back(v);
    endfunction

    logic prev_sel, prev_en;

    // Drive one row's inputs, let one clock edge pass, then check its expectations.
    task automatic applyStimulus(input int idx, input vec_t v);
        req     = v.req;
        sel_req = v.sel_req;
        rst     = v.rst;
        @(negedge clk);
        checkOutput($sformatf("row%0d ack", idx), ack, v.ack);
        checkOutput($sformatf("row%0d busy", idx), busy, v.busy);
        checkOutput($sformatf("row%0d sel", idx), sel, v.sel);
        checkOutput($sformatf("row%0d clk_en", idx), clk_en, v.clk_en);
        if (!v.rst && idx > 0 && sel !== prev_sel)
            checkOutput($sformatf("row%0d sel moved while clock ran", idx),
                        prev_en | clk_en, 1'b0);
        prev_sel = sel;
        prev_en  = clk_en;
    endtask

    initial begin
        int phase;
        logic exp_sel;
        rst = 1'b1; req = 1'b0; sel_req = 1'b0;
        rst2 = 1'b1; req2 = 1'b0; sel_req2 = 1'b0;
        prev_sel = 1'b0; prev_en = 1'b1;

        // reset held two cycles, then idle
        add_vec(0,0,1, 0,0,0,1);
        add_vec(0,0,1, 0,0,0,1);
        add_vec(0,0,0, 0,0,0,1);
        // switch 0->1, stray request (target 0) sampled at t0+3
        add_vec(1,1,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(1,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 1,1,1,1);
        add_vec(0,0,0, 0,0,1,1);
        add_vec(0,0,0, 0,0,1,1);
        // switch 1->0
        add_vec(1,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 1,1,0,1);
        add_vec(0,0,0, 0,0,0,1);
        // no-op request, target already selected
        add_vec(1,0,0, 1,1,0,1);
        add_vec(0,0,0, 0,0,0,1);
        // switch 0->1 aborted by reset while settling
        add_vec(1,1,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,0,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,0, 0,1,1,0);
        add_vec(0,0,1, 0,0,0,1);
        add_vec(0,0,0, 0,0,0,1);
        add_vec(0,0,0, 0,0,0,1);

        foreach (vecs[i]) applyStimulus(i, vecs[i]);

        // Fast instance: request held high with alternating targets.
        rst2 = 1'b0;
        @(negedge clk);
        checkOutput("fast reset ack", ack2, 1'b0);
        checkOutput("fast reset busy", busy2, 1'b0);
        checkOutput("fast reset sel", sel2, 1'b0);
        checkOutput("fast reset clk_en", clk_en2, 1'b1);
        prev_sel = sel2;
        prev_en  = clk_en2;
        req2 = 1'b1;
        sel_req2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            phase   = (k - 1) % 4;
            exp_sel = (((k + 2) / 4) % 2) == 1;
            checkOutput($sformatf("fast k%0d ack", k), ack2, phase == 2);
            checkOutput($sformatf("fast k%0d busy", k), busy2, phase != 3);
            checkOutput($sformatf("fast k%0d clk_en", k), clk_en2, phase >= 2);
            checkOutput($sformatf("fast k%0d sel", k), sel2, exp_sel);
            if (sel2 !== prev_sel)
                checkOutput($sformatf("fast k%0d sel moved while clock ran", k),
                            prev_en | clk_en2, 1'b0);
            prev_sel = sel2;
            prev_en  = clk_en2;
            if (phase == 2) sel_req2 = ~sel_req2;
        end
        req2 = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
